// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use hazard detection.
// Feeds ALU operands directly and passes memory/writeback controls on to EX/MEM.
module id_ex_stage (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        id_valid,
   input  logic [31:0] id_pc,
   input  logic [31:0] id_rs_data,
   input  logic [31:0] id_rt_data,
   input  logic [31:0] id_imm,
   input  logic [4:0]  id_shamt,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic [4:0]  id_rd,
   input  logic [3:0]  id_aluctr,
   input  logic        id_alusrc,
   input  logic        id_uses_rt,
   input  logic        id_regwrite,
   input  logic        id_memread,
   input  logic        id_memwrite,
   input  logic        id_memtoreg,
   input  logic        flush,
   input  logic        mem_regwrite,
   input  logic [4:0]  mem_rd,
   input  logic [31:0] mem_result,
   input  logic        wb_regwrite,
   input  logic [4:0]  wb_rd,
   input  logic [31:0] wb_data,
   output logic        stall,
   output logic [31:0] in1,
   output logic [31:0] in2,
   output logic [4:0]  shf,
   output logic [31:0] out_pc,
   output logic [3:0]  aluctr,
   output logic [31:0] ex_store_data,
   output logic [4:0]  ex_rd,
   output logic        ex_valid,
   output logic        ex_regwrite,
   output logic        ex_memread,
   output logic        ex_memwrite,
   output logic        ex_memtoreg
);

   logic        valid_q;
   logic [31:0] pc_q;
   logic [31:0] rs_data_q;
   logic [31:0] rt_data_q;
   logic [31:0] imm_q;
   logic [4:0]  shamt_q;
   logic [4:0]  rs_q;
   logic [4:0]  rt_q;
   logic [4:0]  rd_q;
   logic [3:0]  aluctr_q;
   logic        alusrc_q;
   logic        regwrite_q;
   logic        memread_q;
   logic        memwrite_q;
   logic        memtoreg_q;

   logic [31:0] fwd_rs;
   logic [31:0] fwd_rt;
   logic        rt_hit;

   // A load in EX whose target an ID source reads cannot be forwarded in time.
   assign rt_hit = (rt_q == id_rs) | (id_uses_rt & (rt_q == id_rt));
   assign stall  = valid_q & memread_q & (rt_q != 5'd0) & id_valid & ~flush & rt_hit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q    <= 1'b0;
         pc_q       <= '0;
         rs_data_q  <= '0;
         rt_data_q  <= '0;
         imm_q      <= '0;
         shamt_q    <= '0;
         rs_q       <= '0;
         rt_q       <= '0;
         rd_q       <= '0;
         aluctr_q   <= '0;
         alusrc_q   <= 1'b0;
         regwrite_q <= 1'b0;
         memread_q  <= 1'b0;
         memwrite_q <= 1'b0;
         memtoreg_q <= 1'b0;
      end else if (flush | stall) begin
         // Bubble: only valid and controls matter, data fields simply hold.
         valid_q    <= 1'b0;
         regwrite_q <= 1'b0;
         memread_q  <= 1'b0;
         memwrite_q <= 1'b0;
         memtoreg_q <= 1'b0;
      end else begin
         valid_q    <= id_valid;
         pc_q       <= id_pc;
         rs_data_q  <= id_rs_data;
         rt_data_q  <= id_rt_data;
         imm_q      <= id_imm;
         shamt_q    <= id_shamt;
         rs_q       <= id_rs;
         rt_q       <= id_rt;
         rd_q       <= id_rd;
         aluctr_q   <= id_aluctr;
         alusrc_q   <= id_alusrc;
         regwrite_q <= id_regwrite & id_valid;
         memread_q  <= id_memread  & id_valid;
         memwrite_q <= id_memwrite & id_valid;
         memtoreg_q <= id_memtoreg & id_valid;
      end
   end

   // Later assignment wins, so EX/MEM takes priority over MEM/WB.
   always_comb begin
      fwd_rs = rs_data_q;
      if (wb_regwrite && (wb_rd != 5'd0) && (wb_rd == rs_q))
         fwd_rs = wb_data;
      if (mem_regwrite && (mem_rd != 5'd0) && (mem_rd == rs_q))
         fwd_rs = mem_result;
   end

   always_comb begin
      fwd_rt = rt_data_q;
      if (wb_regwrite && (wb_rd != 5'd0) && (wb_rd == rt_q))
         fwd_rt = wb_data;
      if (mem_regwrite && (mem_rd != 5'd0) && (mem_rd == rt_q))
         fwd_rt = mem_result;
   end

   assign in1           = fwd_rs;
   assign in2           = alusrc_q ? imm_q : fwd_rt;
   assign ex_store_data = fwd_rt;
   assign shf           = shamt_q;
   assign out_pc        = pc_q;
   assign aluctr        = aluctr_q;
   assign ex_rd         = rd_q;
   assign ex_valid      = valid_q;
   assign ex_regwrite   = regwrite_q;
   assign ex_memread    = memread_q;
   assign ex_memwrite   = memwrite_q;
   assign ex_memtoreg   = memtoreg_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: stimulus queues expected EX outputs per cycle,
// a negedge monitor pops and compares them.
module tb_id_ex_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        id_valid;
   logic [31:0] id_pc, id_rs_data, id_rt_data, id_imm;
   logic [4:0]  id_shamt, id_rs, id_rt, id_rd;
   logic [3:0]  id_aluctr;
   logic        id_alusrc, id_uses_rt;
   logic        id_regwrite, id_memread, id_memwrite, id_memtoreg;
   logic        flush;
   logic        mem_regwrite;
   logic [4:0]  mem_rd;
   logic [31:0] mem_result;
   logic        wb_regwrite;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        stall;
   logic [31:0] in1, in2, out_pc, ex_store_data;
   logic [4:0]  shf, ex_rd;
   logic [3:0]  aluctr;
   logic        ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg;

   id_ex_stage dut (
      .clk(clk), .rst_n(rst_n),
      .id_valid(id_valid), .id_pc(id_pc), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
      .id_imm(id_imm), .id_shamt(id_shamt), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
      .id_aluctr(id_aluctr), .id_alusrc(id_alusrc), .id_uses_rt(id_uses_rt),
      .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
      .id_memtoreg(id_memtoreg), .flush(flush),
      .mem_regwrite(mem_regwrite), .mem_rd(mem_rd), .mem_result(mem_result),
      .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
      .stall(stall), .in1(in1), .in2(in2), .shf(shf), .out_pc(out_pc), .aluctr(aluctr),
      .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_valid(ex_valid),
      .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
      .ex_memtoreg(ex_memtoreg)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int unsigned cyc;
      string       name;
      bit          chk_data;
      logic        stall;
      logic [31:0] in1, in2;
      logic [4:0]  shf;
      logic [31:0] pc;
      logic [3:0]  aluctr;
      logic [31:0] store;
      logic [4:0]  rd;
      logic        valid;
      logic [3:0]  ctrl;
   } exp_t;

   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic id_set(input logic v, input logic [31:0] pc, input logic [31:0] rsd,
                         input logic [31:0] rtd, input logic [31:0] imm, input logic [4:0] shamt,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic [3:0] alu, input logic alusrc, input logic uses_rt,
                         input logic [3:0] ctrl);
      id_valid   = v;     id_pc      = pc;    id_rs_data = rsd;   id_rt_data = rtd;
      id_imm     = imm;   id_shamt   = shamt; id_rs      = rs;    id_rt      = rt;
      id_rd      = rd;    id_aluctr  = alu;   id_alusrc  = alusrc;
      id_uses_rt = uses_rt;
      {id_regwrite, id_memread, id_memwrite, id_memtoreg} = ctrl;
   endtask

   task automatic fwd_set(input logic mrw, input logic [4:0] mrd, input logic [31:0] mres,
                          input logic wrw, input logic [4:0] wrd, input logic [31:0] wdat);
      mem_regwrite = mrw; mem_rd = mrd; mem_result = mres;
      wb_regwrite  = wrw; wb_rd  = wrd; wb_data    = wdat;
   endtask

   task automatic expect_all(input string name, input logic st, input logic [31:0] i1,
                             input logic [31:0] i2, input logic [4:0] sh, input logic [31:0] pc,
                             input logic [3:0] alu, input logic [31:0] sd, input logic [4:0] rd,
                             input logic v, input logic [3:0] ctrl);
      exp_t e;
      e.cyc = cyc; e.name = name; e.chk_data = 1'b1; e.stall = st;
      e.in1 = i1; e.in2 = i2; e.shf = sh; e.pc = pc; e.aluctr = alu;
      e.store = sd; e.rd = rd; e.valid = v; e.ctrl = ctrl;
      sb_q.push_back(e);
   endtask

   task automatic expect_ctl(input string name, input logic st, input logic v,
                             input logic [3:0] ctrl);
      exp_t e;
      e.cyc = cyc; e.name = name; e.chk_data = 1'b0; e.stall = st;
      e.in1 = '0; e.in2 = '0; e.shf = '0; e.pc = '0; e.aluctr = '0;
      e.store = '0; e.rd = '0; e.valid = v; e.ctrl = ctrl;
      sb_q.push_back(e);
   endtask

   always @(negedge clk) begin
      exp_t e;
      logic [3:0] act_ctrl;
      bit bad;
      while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
         e = sb_q.pop_front();
         n_cmp++;
         act_ctrl = {ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg};
         if (e.cyc < cyc) begin
            n_bad++;
            $display("FAIL %s: sampled in cycle %0d, required cycle %0d", e.name, cyc, e.cyc);
         end else begin
            bad = (stall !== e.stall) || (ex_valid !== e.valid) || (act_ctrl !== e.ctrl);
            if (e.chk_data)
               bad = bad || (in1 !== e.in1) || (in2 !== e.in2) || (shf !== e.shf) ||
                     (out_pc !== e.pc) || (aluctr !== e.aluctr) ||
                     (ex_store_data !== e.store) || (ex_rd !== e.rd);
            if (bad) begin
               n_bad++;
               $display("FAIL %s: got stall=%b valid=%b ctrl=%b in1=%h in2=%h shf=%0d pc=%h alu=%h st=%h rd=%0d | want stall=%b valid=%b ctrl=%b in1=%h in2=%h shf=%0d pc=%h alu=%h st=%h rd=%0d (data checked=%0d)",
                        e.name, stall, ex_valid, act_ctrl, in1, in2, shf, out_pc, aluctr,
                        ex_store_data, ex_rd, e.stall, e.valid, e.ctrl, e.in1, e.in2, e.shf,
                        e.pc, e.aluctr, e.store, e.rd, e.chk_data);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset held with every input nonzero.
      rst_n = 1'b0;
      flush = 1'b1;
      id_set(1, 32'hFFFF_FFF0, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 32'h0F0F_0F0F, 5'd31,
             5'd3, 5'd4, 5'd5, 4'hF, 1, 1, 4'hF);
      fwd_set(1, 5'd3, 32'h1111_1111, 1, 5'd4, 32'h2222_2222);
      repeat (3) step();
      expect_all("reset_hold", 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000);

      step();
      rst_n = 1'b1;
      flush = 1'b0;
      fwd_set(0, 0, 0, 0, 0, 0);
      id_set(1, 32'h100, 32'h11, 32'h22, 32'h33, 5'd3, 5'd1, 5'd2, 5'd3, 4'd2, 0, 1, 4'b1000);
      expect_all("deassert_no_edge", 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000);

      step();
      id_set(1, 32'h104, 32'hAAAA, 32'h66, 0, 5'd0, 5'd5, 5'd6, 5'd7, 4'd1, 0, 1, 4'b1000);
      expect_all("load_first", 0, 32'h11, 32'h22, 5'd3, 32'h100, 4'd2, 32'h22, 5'd3, 1, 4'b1000);

      step();
      fwd_set(1, 5'd5, 32'h1234, 1, 5'd5, 32'hFFFF);
      id_set(1, 32'h108, 0, 32'h99, 0, 5'd31, 5'd0, 5'd9, 5'd10, 4'd3, 0, 1, 4'b1000);
      expect_all("fwd_mem_priority", 0, 32'h1234, 32'h66, 5'd0, 32'h104, 4'd1, 32'h66, 5'd7, 1, 4'b1000);

      step();
      fwd_set(1, 5'd0, 32'hDEAD, 1, 5'd9, 32'h5555);
      id_set(1, 32'h10C, 32'h1000, 0, 32'd4, 5'd0, 5'd1, 5'd8, 5'd8, 4'd2, 1, 0, 4'b1101);
      expect_all("zero_guard_wb_rt", 0, 0, 32'h5555, 5'd31, 32'h108, 4'd3, 32'h5555, 5'd10, 1, 4'b1000);

      // lw $8 now in EX, add reading $8 in ID.
      step();
      fwd_set(0, 0, 0, 0, 0, 0);
      id_set(1, 32'h110, 0, 32'h22, 0, 5'd0, 5'd8, 5'd2, 5'd4, 4'd2, 0, 1, 4'b1000);
      expect_all("loaduse_stall", 1, 32'h1000, 32'd4, 5'd0, 32'h10C, 4'd2, 0, 5'd8, 1, 4'b1101);

      step();
      fwd_set(1, 5'd8, 32'hBEEF, 0, 0, 0);
      expect_ctl("loaduse_bubble", 0, 0, 4'b0000);

      step();
      fwd_set(0, 0, 0, 1, 5'd8, 32'hBEEF);
      id_set(1, 32'h114, 32'h200, 0, 32'd8, 5'd0, 5'd0, 5'd12, 5'd12, 4'd2, 1, 0, 4'b1101);
      expect_all("add_after_stall", 0, 32'hBEEF, 32'h22, 5'd0, 32'h110, 4'd2, 32'h22, 5'd4, 1, 4'b1000);

      // lw $12 in EX, consumer reads $12 through rt, but a flush arrives.
      step();
      fwd_set(0, 0, 0, 0, 0, 0);
      flush = 1'b1;
      id_set(1, 32'h118, 32'h3, 32'h4, 0, 5'd0, 5'd3, 5'd12, 5'd13, 4'd2, 0, 1, 4'b1000);
      expect_all("flush_beats_stall", 0, 32'h200, 32'd8, 5'd0, 32'h114, 4'd2, 0, 5'd12, 1, 4'b1101);

      step();
      flush = 1'b0;
      id_set(0, 32'h200, 32'd7, 32'd8, 0, 5'd1, 5'd0, 5'd0, 5'd5, 4'd6, 0, 0, 4'b1111);
      expect_ctl("flush_bubble", 0, 0, 4'b0000);

      step();
      id_set(1, 32'h204, 32'd1, 32'd2, 32'h0000_ABCD, 5'd0, 5'd2, 5'd14, 5'd14, 4'hF, 1, 0, 4'b0010);
      expect_all("invalid_gated", 0, 32'd7, 32'd8, 5'd1, 32'h200, 4'd6, 32'd8, 5'd5, 0, 4'b0000);

      step();
      fwd_set(1, 5'd14, 32'hCAFE, 0, 0, 0);
      id_set(1, 32'h208, 32'h300, 0, 0, 5'd0, 5'd0, 5'd20, 5'd20, 4'd2, 1, 0, 4'b1101);
      expect_all("imm_path", 0, 32'd1, 32'h0000_ABCD, 5'd0, 32'h204, 4'hF, 32'hCAFE, 5'd14, 1, 4'b0010);

      step();
      fwd_set(0, 0, 0, 0, 0, 0);
      id_set(1, 32'h20C, 32'h5, 32'h6, 0, 5'd0, 5'd1, 5'd20, 5'd0, 4'd0, 0, 1, 4'b0010);
      expect_all("loaduse_rt", 1, 32'h300, 0, 5'd0, 32'h208, 4'd2, 0, 5'd20, 1, 4'b1101);

      step();
      expect_ctl("loaduse_rt_bubble", 0, 0, 4'b0000);

      // Consumer now sits in EX; reset mid-cycle must clear it with no edge.
      step();
      rst_n = 1'b0;
      fwd_set(1, 5'd20, 32'h77, 1, 5'd20, 32'h88);
      expect_all("async_reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000);

      step();
      step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
